// File: rtl/tdc_pop_accum.sv
// -----------------------------------------------------------------------------
// tdc_pop_accum
//
// Back end of the TDC popcount path. It sits after the 8-4 compressor bank and
// receives one 4-bit tap count per group of 8 delay-line taps.
//
//   stage 0     : register the group counts, clamping illegal values (9..15)
//                 to 8 and raising the sticky err flag
//   stage 1..LVL: registered binary adder tree. An odd-sized level passes its
//                 last element straight through, which is the same as adding
//                 a zero pad.
//   averaging   : accumulate 2^AVG_LOG2 consecutive codes and emit their
//                 truncated mean on avg_out. There is no dead cycle between
//                 averaging windows.
//
// Latency from a sampled cnt_valid to code_valid is 1+LVL cycles, and the
// pipeline accepts one sample per cycle. There is no backpressure.
//
// Optional feature (define TDC_POP_MINMAX_EN):
//   adds running code_min / code_max outputs. They are updated on every
//   code_valid. Reset and clear return them to all-ones and zero.
// -----------------------------------------------------------------------------
module tdc_pop_accum #(
    parameter int  NUM_GROUPS = 8,                          // 2..32
    parameter int  AVG_LOG2   = 2,                          // 0..6
    localparam int SUM_W      = $clog2(8*NUM_GROUPS+1),
    localparam int LVL        = $clog2(NUM_GROUPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [4*NUM_GROUPS-1:0] cnt_in,
    input  logic                    cnt_valid,
    output logic [SUM_W-1:0]        code_out,
    output logic                    code_valid,
    output logic [SUM_W-1:0]        avg_out,
    output logic                    avg_valid,
    output logic                    err
`ifdef TDC_POP_MINMAX_EN
    ,
    output logic [SUM_W-1:0]        code_min,
    output logic [SUM_W-1:0]        code_max
`endif
);

    // Number of elements held at tree level k. Level 0 holds the groups, and
    // each following level holds half as many elements, rounded up.
    function automatic int lvl_len(input int k);
        return (NUM_GROUPS + (1 << k) - 1) >> k;
    endfunction

    // ------------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------------
    logic [NUM_GROUPS-1:0]      grp_bad;
    logic [NUM_GROUPS-1:0][3:0] grp_clamped;
    logic                       take;

    // A sample is taken only when no flush is requested in the same cycle.
    assign take = cnt_valid & ~clear;

    // Flag each illegal group count and clamp it to the largest legal value, 8.
    always_comb begin
        // NOTE: defaults first, so every path assigns every bit and no latch is inferred.
        grp_bad     = '0;
        grp_clamped = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_bad[g]     = cnt_in[4*g +: 4] > 4'd8;
            grp_clamped[g] = grp_bad[g] ? 4'd8 : cnt_in[4*g +: 4];
        end
    end

    // Sticky error flag. It is set by any illegal group in an accepted sample.
    // Only clear or reset can drop it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the clock edge.
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (cnt_valid && (|grp_bad)) begin
            err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Input register (level 0) and adder tree (levels 1..LVL)
    // ------------------------------------------------------------------------
    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        localparam int N = lvl_len(k);

        logic [SUM_W-1:0] d   [N];  // registered level contents
        logic [SUM_W-1:0] nxt [N];  // value loaded when the level advances
        logic             v;        // registered valid for this level
        logic             v_in;     // valid arriving from the level before

        if (k == 0) begin : g_src
            assign v_in = cnt_valid;
            for (genvar i = 0; i < N; i++) begin : g_node
                assign nxt[i] = SUM_W'(grp_clamped[i]);
            end
        end else begin : g_src
            assign v_in = g_lvl[k-1].v;
            for (genvar i = 0; i < N; i++) begin : g_node
                if (2*i+1 < lvl_len(k-1)) begin : g_pair
                    assign nxt[i] = g_lvl[k-1].d[2*i] + g_lvl[k-1].d[2*i+1];
                end else begin : g_pad
                    // Odd element with no partner. Adding a zero pad leaves it unchanged.
                    assign nxt[i] = g_lvl[k-1].d[2*i];
                end
            end
        end

        // Advance the level when its input is valid. Data holds otherwise, so
        // the last level keeps code_out steady between code_valid pulses.
        // clear drops the valid bit and whatever sample it qualified.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                // NOTE: the tree data registers are reset as well as the valid
                // bits, so code_out reads 0 out of reset with no special case
                // for the last level.
                for (int i = 0; i < N; i++) begin
                    d[i] <= '0;
                end
            end else begin
                v <= v_in & ~clear;
                if (v_in && !clear) begin
                    d <= nxt;
                end
            end
        end
    end

    assign code_out   = g_lvl[LVL].d[0];
    assign code_valid = g_lvl[LVL].v;

    // ------------------------------------------------------------------------
    // Window averaging
    // ------------------------------------------------------------------------
    if (AVG_LOG2 == 0) begin : g_avg_pass
        // A window of one code: forward each code one cycle later.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                avg_valid <= 1'b0;
                avg_out   <= '0;
            end else begin
                avg_valid <= code_valid & ~clear;
                if (code_valid && !clear) begin
                    avg_out <= code_out;
                end
            end
        end
    end else begin : g_avg_win
        localparam int ACC_W = SUM_W + AVG_LOG2;

        logic [ACC_W-1:0]    acc;
        logic [ACC_W-1:0]    acc_sum;
        logic [AVG_LOG2-1:0] cnt;
        logic                last;

        // acc can hold 2^AVG_LOG2 full-scale codes, so this sum cannot overflow.
        assign acc_sum = acc + ACC_W'(code_out);
        assign last    = (cnt == {AVG_LOG2{1'b1}});

        // Accumulate codes. On the final code of a window, publish the mean
        // and restart from zero in the same cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc       <= '0;
                cnt       <= '0;
                avg_out   <= '0;
                avg_valid <= 1'b0;
            end else if (clear) begin
                acc       <= '0;
                cnt       <= '0;
                avg_valid <= 1'b0;
            end else begin
                avg_valid <= code_valid & last;
                if (code_valid) begin
                    if (last) begin
                        avg_out <= SUM_W'(acc_sum >> AVG_LOG2);
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        acc     <= acc_sum;
                        cnt     <= cnt + AVG_LOG2'(1);
                    end
                end
            end
        end
    end

`ifdef TDC_POP_MINMAX_EN
    // ------------------------------------------------------------------------
    // Running extremes of code_out since the last reset or clear
    // ------------------------------------------------------------------------
    // Strict comparisons, so a code equal to an extreme leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_min <= '1;
            code_max <= '0;
        end else if (clear) begin
            code_min <= '1;
            code_max <= '0;
        end else if (code_valid) begin
            if (code_out < code_min) begin
                code_min <= code_out;
            end
            if (code_out > code_max) begin
                code_max <= code_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tdc_pop_accum.sv
// -----------------------------------------------------------------------------
// tb_tdc_pop_accum
//
// Directed bench for tdc_pop_accum. There are two instances:
//   dut  : NUM_GROUPS=8, AVG_LOG2=2 (default configuration)
//   dut5 : NUM_GROUPS=5, AVG_LOG2=0 (odd tree level, pass-through averaging)
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Define TDC_POP_MINMAX_EN to also exercise code_min / code_max on dut5.
// -----------------------------------------------------------------------------
module tb_tdc_pop_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        clear = 1'b0;
    logic [31:0] cnt_in = '0;
    logic        cnt_valid = 1'b0;
    logic [6:0]  code_out;
    logic        code_valid;
    logic [6:0]  avg_out;
    logic        avg_valid;
    logic        err;

    logic        clear5 = 1'b0;
    logic [19:0] cnt_in5 = '0;
    logic        cnt_valid5 = 1'b0;
    logic [5:0]  code_out5;
    logic        code_valid5;
    logic [5:0]  avg_out5;
    logic        avg_valid5;
    logic        err5;
`ifdef TDC_POP_MINMAX_EN
    logic [6:0]  code_min;
    logic [6:0]  code_max;
    logic [5:0]  code_min5;
    logic [5:0]  code_max5;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Stimulus tables, with expected codes and averages worked out by hand.
    logic [31:0] b2b_vec [3]  = '{32'h1111_1111, 32'h3333_3333, 32'h0000_0005};
    int          b2b_code [3] = '{8, 24, 5};
    logic [31:0] avg_vec [8]  = '{32'h28, 32'h38, 32'h48, 32'h68,
                                  32'h488, 32'h488, 32'h488, 32'h488};
    int          avg_code [8] = '{10, 11, 12, 14, 20, 20, 20, 20};
    logic [31:0] win_vec [4]  = '{32'h0008_8888, 32'h0008_8888, 32'h0008_8888, 32'h0};
    int          win_code [4] = '{40, 40, 40, 0};
    logic [19:0] odd_vec [3]  = '{20'h77777, 20'h44444, 20'h88888};
    int          odd_code [3] = '{35, 20, 40};

    always #5 clk = ~clk;

    tdc_pop_accum #(.NUM_GROUPS(8), .AVG_LOG2(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .cnt_in     (cnt_in),
        .cnt_valid  (cnt_valid),
        .code_out   (code_out),
        .code_valid (code_valid),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .err        (err)
`ifdef TDC_POP_MINMAX_EN
        ,
        .code_min   (code_min),
        .code_max   (code_max)
`endif
    );

    tdc_pop_accum #(.NUM_GROUPS(5), .AVG_LOG2(0)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear5),
        .cnt_in     (cnt_in5),
        .cnt_valid  (cnt_valid5),
        .code_out   (code_out5),
        .code_valid (code_valid5),
        .avg_out    (avg_out5),
        .avg_valid  (avg_valid5),
        .err        (err5)
`ifdef TDC_POP_MINMAX_EN
        ,
        .code_min   (code_min5),
        .code_max   (code_max5)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog, so the run always ends even if the clock stops advancing the bench.
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset with live, random input ----------------
        cnt_valid  = 1'b1;
        cnt_valid5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt_in  = $urandom;
            cnt_in5 = 20'($urandom);
            step();
        end
        check("rst code_valid", code_valid, 0);
        check("rst code_out",   code_out,   0);
        check("rst avg_valid",  avg_valid,  0);
        check("rst avg_out",    avg_out,    0);
        check("rst err",        err,        0);
        check("rst code_valid5", code_valid5, 0);
`ifdef TDC_POP_MINMAX_EN
        check("rst code_min5", code_min5, 63);
        check("rst code_max5", code_max5, 0);
`endif
        cnt_valid  = 1'b0;
        cnt_valid5 = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("post-rst valids c%0d", i),
                  {code_valid, avg_valid, code_valid5, avg_valid5}, 0);
        end

        // ---------------- single full-scale sample ----------------
        cnt_in    = 32'h8888_8888;
        cnt_valid = 1'b1;
        step();
        cnt_valid = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            if (s > 1) step();
            check($sformatf("single code_valid s%0d", s), code_valid, 32'(s == 4));
            if (s >= 4) check($sformatf("single code_out s%0d", s), code_out, 64);
        end

        // ---------------- back-to-back samples ----------------
        // The window already holds 64, so the 4th code (5) closes it: (64+8+24+5)>>2 = 25.
        for (int s = 0; s < 8; s++) begin
            cnt_valid = (s < 3);
            if (s < 3) cnt_in = b2b_vec[s];
            step();
            if (s >= 3 && s <= 5) begin
                check($sformatf("b2b code_valid s%0d", s), code_valid, 1);
                check($sformatf("b2b code_out s%0d", s), code_out, b2b_code[s-3]);
            end else begin
                check($sformatf("b2b code_valid s%0d", s), code_valid, 0);
            end
            check($sformatf("b2b avg_valid s%0d", s), avg_valid, 32'(s == 6));
            if (s == 6) check("b2b avg_out", avg_out, 25);
        end

        // ---------------- averaging: 10,11,12,14 -> 11 ; 4x20 -> 20 ----------------
        for (int s = 0; s < 13; s++) begin
            cnt_valid = (s < 8);
            if (s < 8) cnt_in = avg_vec[s];
            step();
            if (s >= 3 && s <= 10) begin
                check($sformatf("avg code_out s%0d", s), code_out, avg_code[s-3]);
                check($sformatf("avg code_valid s%0d", s), code_valid, 1);
            end else begin
                check($sformatf("avg code_valid s%0d", s), code_valid, 0);
            end
            check($sformatf("avg avg_valid s%0d", s), avg_valid, 32'(s == 7 || s == 11));
            if (s >= 7 && s < 11) check($sformatf("avg avg_out s%0d", s), avg_out, 11);
            if (s >= 11) check($sformatf("avg avg_out s%0d", s), avg_out, 20);
        end

        // ---------------- illegal group count ----------------
        cnt_in    = 32'h0000_C000;   // group 3 = 12, clamped to 8
        cnt_valid = 1'b1;
        step();
        cnt_valid = 1'b0;
        check("illegal err set", err, 1);
        repeat (3) step();
        check("illegal code_valid", code_valid, 1);
        check("illegal code_out",   code_out,   8);
        check("illegal err held",   err,        1);
        step();   // code 8 now sits in the window (counter 1)

        // ---------------- clear with one sample in flight and one offered ----------------
        cnt_in    = 32'h2222_2222;
        cnt_valid = 1'b1;
        step();
        cnt_valid = 1'b0;
        step();
        clear     = 1'b1;
        cnt_valid = 1'b1;
        cnt_in    = 32'h8888_8888;
        step();
        clear     = 1'b0;
        cnt_valid = 1'b0;
        check("clear err", err, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("clear no valid c%0d", i), {code_valid, avg_valid}, 0);
        end

        // The window restarts at counter 0: (40+40+40+0)>>2 = 30 on the 4th code.
        for (int s = 0; s < 9; s++) begin
            cnt_valid = (s < 4);
            if (s < 4) cnt_in = win_vec[s];
            step();
            if (s >= 3 && s <= 6)
                check($sformatf("win code_out s%0d", s), code_out, win_code[s-3]);
            check($sformatf("win avg_valid s%0d", s), avg_valid, 32'(s == 7));
            if (s == 7) check("win avg_out", avg_out, 30);
        end

        // ---------------- clear together with the final code of a window ----------------
        for (int s = 0; s < 7; s++) begin
            cnt_valid = (s < 4);
            cnt_in    = 32'h1;
            step();
        end
        check("fin code_valid", code_valid, 1);
        check("fin code_out",   code_out,   1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("fin avg_valid suppressed", avg_valid, 0);
        check("fin avg_out unchanged",    avg_out,   30);

        // ---------------- odd group count, AVG_LOG2=0 ----------------
        for (int s = 0; s < 8; s++) begin
            cnt_valid5 = (s < 3);
            if (s < 3) cnt_in5 = odd_vec[s];
            step();
            if (s >= 3 && s <= 5) begin
                check($sformatf("odd code_valid s%0d", s), code_valid5, 1);
                check($sformatf("odd code_out s%0d", s), code_out5, odd_code[s-3]);
            end else begin
                check($sformatf("odd code_valid s%0d", s), code_valid5, 0);
            end
            check($sformatf("odd avg_valid s%0d", s), avg_valid5, 32'(s >= 4 && s <= 6));
            if (s >= 4 && s <= 6) check($sformatf("odd avg_out s%0d", s), avg_out5, odd_code[s-4]);
        end
        check("odd err", err5, 0);
`ifdef TDC_POP_MINMAX_EN
        check("odd code_min", code_min5, 20);
        check("odd code_max", code_max5, 40);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tdc_pop_accum.md
Name: tdc_pop_accum

Overview:
- Downstream stage of the 8-4 compressor bank in the TDC popcount path.
- Takes the 4-bit group counts from NUM_GROUPS compressor instances, each instance covering 8 delay-line taps.
- Sums the counts in a registered adder tree to form the per-strobe thermometer code.
- Also averages 2^AVG_LOG2 consecutive codes into a decimated measurement for the readout logic.

Parameters:
- NUM_GROUPS, 8: number of 4-bit group counts. Legal range 2..32. 8 groups = 64 taps.
- AVG_LOG2, 2: log2 of the averaging window. Legal range 0..6. 0 makes avg_out equal to code_out.
- SUM_W (localparam): $clog2(8*NUM_GROUPS+1). 7 at default.
- LVL (localparam): $clog2(NUM_GROUPS). 3 at default.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deasserts to run.
- clear  in  1  synchronous flush of pipeline, accumulator, sample counter and err.
- cnt_in  in  4*NUM_GROUPS  group counts; group g occupies bits [4g+3:4g].
- cnt_valid  in  1  cnt_in holds a new sample this cycle. No backpressure exists.
- code_out  out  SUM_W  total taps set for one sample.
- code_valid  out  1  one-cycle pulse qualifying code_out.
- avg_out  out  SUM_W  truncated mean of the last 2^AVG_LOG2 codes.
- avg_valid  out  1  one-cycle pulse qualifying avg_out.
- err  out  1  sticky flag: a group count above 8 was received.

Behaviour:
- Reset (rst_n low, async): all valid bits, code_out, avg_out, accumulator, sample counter and err go to 0.
- Stage 0 (input register):
  - On cnt_valid, each group is registered, with values >8 clamped to 8.
  - Group counts are 0..8 by construction, so 9..15 is illegal input.
  - Any illegal group sets err. err stays set until clear or reset.
- Stages 1..LVL (adder tree):
  - Each level adds adjacent pairs and registers the result.
  - An odd element count at a level is padded with zero.
  - Every level has a valid bit that shifts alongside the data.
- Latency: exactly 1+LVL cycles from a sampled cnt_valid to code_valid. 4 cycles at default.
  - Throughput is one sample per cycle, including back-to-back samples.
  - Gaps in cnt_valid propagate as gaps in code_valid.
- code_out holds its last value when code_valid is low.
- Arithmetic never overflows: the maximum sum 8*NUM_GROUPS fits in SUM_W.
- Averaging:
  - Accumulator width is SUM_W+AVG_LOG2. The sample counter is AVG_LOG2 bits.
  - On code_valid with counter below 2^AVG_LOG2-1: acc += code_out; counter increments.
  - On code_valid with counter = 2^AVG_LOG2-1:
    - avg_out <= (acc+code_out) >> AVG_LOG2 (truncation).
    - avg_valid pulses the following cycle.
    - acc and counter return to 0 in that same cycle, so there is no dead cycle between windows.
  - AVG_LOG2=0: avg_valid is code_valid delayed one cycle, and avg_out equals that code.
- clear:
  - Zeroes all pipeline valid bits, acc, counter and err in one cycle. Data registers may keep stale values.
  - clear together with cnt_valid: clear wins and the sample is dropped.
  - clear together with a final-window code_valid: no avg_valid is produced.
  - Samples already in flight are discarded.
- Reset mid-operation: all in-flight samples and partial averages are lost, with no spurious valid after release.

Optional Feature:
- Macro: TDC_POP_MINMAX_EN.
- Defined:
  - Adds outputs code_min and code_max, each SUM_W wide.
  - Both update on every code_valid, with the same timing as the accumulator.
  - Reset and clear set code_min to all-ones and code_max to 0.
  - A code equal to the current extreme leaves it unchanged.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n low with random cnt_in and cnt_valid=1. Required: all outputs 0. Release rst_n with cnt_valid=0. Required: no valid pulses for 10 cycles.
- Single sample: NUM_GROUPS=8, all groups=8, one cnt_valid pulse. Required: code_valid exactly 4 cycles later, with code_out=64.
- Back-to-back samples: groups all 1, then all 3, then g0=5 with the rest 0, on consecutive cycles. Required: codes 8, 24, 5 on three consecutive code_valid cycles.
- Averaging: AVG_LOG2=2, codes 10, 11, 12, 14. Required: avg_out=11 (47>>2), with avg_valid pulsing one cycle after the fourth code_valid. The next window of 4x20 gives 20.
- Illegal input and clear: group 3=12, others 0. Required: code_out=8 and err=1. Assert clear mid-window with a sample in flight. Required: err=0, no code_valid for the dropped sample, and the next window starts from counter 0.
- Odd group count: NUM_GROUPS=5, all groups=7. Required: code_out=35 after 4 cycles. With TDC_POP_MINMAX_EN, codes 35, 20, 40 give code_min=20 and code_max=40.
